// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding the register-file write port.
// ALU results retire straight through; loads wait for the data-memory
// response (with a timeout guard), then the addressed lane is extracted and extended.
module wb_stage #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_dst,
    input  logic [31:0]      in_alu,
    input  logic             in_is_load,
    input  logic [1:0]       in_ld_size,
    input  logic             in_ld_unsigned,
    input  logic [1:0]       in_byte_off,
    input  logic             dm_rvalid,
    input  logic [31:0]      dm_rdata,
    output logic [4:0]       rwd,
    output logic [31:0]      wb_data,
    output logic [4:0]       wb_pend_dst,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

    localparam logic [7:0]       TMO_LAST = 8'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state, state_nx;
    logic [4:0]         ld_dst, ld_dst_nx;
    logic [1:0]         ld_size, ld_size_nx;
    logic               ld_uns, ld_uns_nx;
    logic [1:0]         ld_off, ld_off_nx;
    logic [7:0]         tcnt, tcnt_nx;
    logic [4:0]         rwd_nx;
    logic [31:0]        wb_data_nx;
    logic               err_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic [7:0]         lane8;
    logic [15:0]        lane16;
    logic [31:0]        load_data;

    // Stage can take a new instruction only when idle and not in reset.
    always_comb begin
        in_ready    = (state == IDLE) && !RST;
        wb_pend_dst = (state == WAIT_LOAD) ? ld_dst : 5'd0;
    end

    // Lane select and extension of the returned memory word.
    always_comb begin
        case (ld_off)
            2'd0:    lane8 = dm_rdata[7:0];
            2'd1:    lane8 = dm_rdata[15:8];
            2'd2:    lane8 = dm_rdata[23:16];
            default: lane8 = dm_rdata[31:24];
        endcase
        // Misaligned halves fall back to the half selected by off[1].
        lane16 = ld_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (ld_size)
            2'd0:    load_data = {{24{lane8[7] & ~ld_uns}}, lane8};
            2'd1:    load_data = {{16{lane16[15] & ~ld_uns}}, lane16};
            default: load_data = dm_rdata;
        endcase
    end

    // Next-state and writeback decisions; rwd defaults to 0 so it pulses once per retire.
    always_comb begin
        state_nx   = state;
        ld_dst_nx  = ld_dst;
        ld_size_nx = ld_size;
        ld_uns_nx  = ld_uns;
        ld_off_nx  = ld_off;
        tcnt_nx    = tcnt;
        rwd_nx     = 5'd0;
        wb_data_nx = wb_data;
        err_nx     = err_timeout;
        cnt_nx     = retired_cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_is_load) begin
                        ld_dst_nx  = in_dst;
                        ld_size_nx = in_ld_size;
                        ld_uns_nx  = in_ld_unsigned;
                        ld_off_nx  = in_byte_off;
                        tcnt_nx    = 8'd0;
                        state_nx   = WAIT_LOAD;
                    end else begin
                        rwd_nx     = in_dst;
                        wb_data_nx = in_alu;
                        cnt_nx     = retired_cnt + CNT_ONE;
                    end
                end
            end
            WAIT_LOAD: begin
                // A response arriving on the timeout cycle still retires the load.
                if (dm_rvalid) begin
                    rwd_nx     = ld_dst;
                    wb_data_nx = load_data;
                    cnt_nx     = retired_cnt + CNT_ONE;
                    state_nx   = IDLE;
                end else if (tcnt == TMO_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    tcnt_nx = tcnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            ld_dst      <= 5'd0;
            ld_size     <= 2'd0;
            ld_uns      <= 1'b0;
            ld_off      <= 2'd0;
            tcnt        <= 8'd0;
            rwd         <= 5'd0;
            wb_data     <= 32'd0;
            err_timeout <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state       <= state_nx;
            ld_dst      <= ld_dst_nx;
            ld_size     <= ld_size_nx;
            ld_uns      <= ld_uns_nx;
            ld_off      <= ld_off_nx;
            tcnt        <= tcnt_nx;
            rwd         <= rwd_nx;
            wb_data     <= wb_data_nx;
            err_timeout <= err_nx;
            retired_cnt <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: transaction-level reference model driving directed and random
// ALU/load instructions into wb_stage; inputs change and outputs are sampled on negedge.
module tb_wb_stage;

    localparam int LT = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dst;
    logic [31:0] in_alu;
    logic        in_is_load;
    logic [1:0]  in_ld_size;
    logic        in_ld_unsigned;
    logic [1:0]  in_byte_off;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic [4:0]  rwd;
    logic [31:0] wb_data;
    logic [4:0]  wb_pend_dst;
    logic        err_timeout;
    logic [31:0] retired_cnt;

    wb_stage #(.LOAD_TIMEOUT(LT), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_dst(in_dst), .in_alu(in_alu), .in_is_load(in_is_load),
        .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
        .in_byte_off(in_byte_off), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .rwd(rwd), .wb_data(wb_data), .wb_pend_dst(wb_pend_dst),
        .err_timeout(err_timeout), .retired_cnt(retired_cnt)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_wb;
    logic [31:0] exp_cnt;
    logic        exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference lane extraction from plain shift/mask arithmetic.
    function automatic logic [31:0] ref_extract(input logic [31:0] d, input int sz,
                                                input bit uns, input int off);
        logic [31:0] v;
        if (sz == 0) begin
            v = (d >> (8 * off)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (d >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; in_is_load = 1'b0; in_dst = 5'd0; in_alu = 32'd0;
        in_ld_size = 2'd0; in_ld_unsigned = 1'b0; in_byte_off = 2'd0;
    endtask

    task automatic check_state(input string tag, input logic [4:0] e_rwd,
                               input logic e_rdy, input logic [4:0] e_pend);
        chk({tag, ".rwd"}, 32'(rwd), 32'(e_rwd));
        chk({tag, ".wb_data"}, wb_data, exp_wb);
        chk({tag, ".cnt"}, retired_cnt, exp_cnt);
        chk({tag, ".err"}, 32'(err_timeout), 32'(exp_err));
        chk({tag, ".ready"}, 32'(in_ready), 32'(e_rdy));
        chk({tag, ".pend"}, 32'(wb_pend_dst), 32'(e_pend));
    endtask

    // Called at a negedge with the stage idle; returns at a negedge.
    task automatic do_alu(input logic [4:0] dst, input logic [31:0] alu);
        chk("alu.ready_pre", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_is_load = 1'b0; in_dst = dst; in_alu = alu;
        dm_rvalid = 1'($urandom); dm_rdata = $urandom;   // must be ignored in IDLE
        @(negedge CLK);
        exp_wb = alu; exp_cnt = exp_cnt + 1;
        check_state("alu", dst, 1'b1, 5'd0);
        idle_inputs(); dm_rvalid = 1'b0;
    endtask

    // delay = number of WAIT cycles before the response; delay >= LT never responds.
    task automatic do_load(input logic [4:0] dst, input int sz, input bit uns, input int off,
                           input int delay, input logic [31:0] data);
        bit done;
        chk("ld.ready_pre", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_is_load = 1'b1; in_dst = dst; in_alu = $urandom;
        in_ld_size = 2'(sz); in_ld_unsigned = uns; in_byte_off = 2'(off);
        dm_rvalid = 1'b0;
        @(negedge CLK);
        idle_inputs();
        check_state("ld.accept", 5'd0, 1'b0, dst);
        done = 1'b0;
        for (int k = 0; k < LT && !done; k++) begin
            dm_rvalid = (k == delay);
            dm_rdata  = (k == delay) ? data : $urandom;
            @(negedge CLK);
            dm_rvalid = 1'b0;
            if (k == delay) begin
                exp_wb = ref_extract(data, sz, uns, off); exp_cnt = exp_cnt + 1;
                check_state("ld.retire", dst, 1'b1, 5'd0);
                done = 1'b1;
            end else if (k == LT - 1) begin
                exp_err = 1'b1;
                check_state("ld.timeout", 5'd0, 1'b1, 5'd0);
                done = 1'b1;
            end else begin
                check_state("ld.wait", 5'd0, 1'b0, dst);
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        exp_wb = 32'd0; exp_cnt = 32'd0; exp_err = 1'b0;
        check_state("rst", 5'd0, 1'b0, 5'd0);
        RST = 1'b0;
        #1;
        chk("rst.ready_after", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [4:0]  rd;
        logic [31:0] rv;
        int          sz, off, dly;
        bit          uns;
        idle_inputs();
        dm_rvalid = 1'b0; dm_rdata = 32'd0; RST = 1'b1;
        exp_wb = 32'd0; exp_cnt = 32'd0; exp_err = 1'b0;
        @(negedge CLK);
        do_reset();

        // back-to-back ALU retirement
        do_alu(5'd3, 32'h11);
        do_alu(5'd4, 32'h22);
        do_alu(5'd5, 32'h33);
        chk("alu3.cnt", retired_cnt, 32'd3);

        // lane extraction cases
        do_load(5'd7, 0, 1'b0, 2, 3, 32'h1280_3456);
        chk("ldb.value", wb_data, 32'hFFFF_FF80);
        do_load(5'd8, 1, 1'b1, 2, 0, 32'h8001_ABCD);
        chk("ldhu.value", wb_data, 32'h0000_8001);
        do_load(5'd9, 1, 1'b0, 0, 1, 32'h8001_ABCD);
        chk("ldh.value", wb_data, 32'hFFFF_ABCD);
        do_load(5'd10, 2, 1'b0, 1, 2, 32'h8001_ABCD);
        do_load(5'd11, 3, 1'b0, 3, LT - 1, 32'h8001_ABCD);   // response on the timeout cycle
        do_load(5'd12, 1, 1'b1, 1, 0, 32'h8001_ABCD);        // misaligned half

        // timeout, then normal ALU retirement with sticky error
        do_load(5'd13, 2, 1'b0, 0, LT + 5, 32'h0);
        do_alu(5'd14, 32'h1234_5678);
        @(negedge CLK);
        check_state("idle", 5'd0, 1'b1, 5'd0);

        // dst=0 retires without a write
        do_alu(5'd0, 32'hDEAD);

        // reset in the middle of a load; late response must be dropped
        in_valid = 1'b1; in_is_load = 1'b1; in_dst = 5'd21; in_ld_size = 2'd2;
        @(negedge CLK);
        idle_inputs();
        repeat (2) @(negedge CLK);
        chk("midrst.pend", 32'(wb_pend_dst), 32'd21);
        do_reset();
        dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
        @(negedge CLK);
        dm_rvalid = 1'b0;
        check_state("midrst.drop", 5'd0, 1'b1, 5'd0);

        // randomized mix
        for (int i = 0; i < 150; i++) begin
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            rv = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                do_alu(rd, rv);
            end else begin
                sz  = $urandom_range(0, 3);
                off = $urandom_range(0, 3);
                uns = 1'($urandom);
                dly = ($urandom_range(0, 9) == 0) ? LT + 1 : $urandom_range(0, 5);
                do_load(rd, sz, uns, off, dly, rv);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge CLK);
                check_state("rnd.idle", 5'd0, 1'b1, 5'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the register file; produces the regfile's write-port pair (rwd, wb_data).
- Accepts one retiring instruction per handshake from the memory stage.
  - ALU results pass straight through.
  - Loads wait for the data-memory response, then extract and extend the addressed byte/half/word.
- Provides a timeout guard on loads and a retired-instruction counter for debug.

Parameters:
- LOAD_TIMEOUT, 16, max cycles spent in WAIT_LOAD before abandoning the load (2..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on posedge CLK.
- RST  in  1  reset; synchronous, active-high.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept; equals (state==IDLE) && !RST.
- in_dst  in  5  destination register number.
- in_alu  in  32  ALU result (non-load instructions).
- in_is_load  in  1  instruction is a load.
- in_ld_size  in  2  0=byte, 1=half, 2=word, 3=treated as word.
- in_ld_unsigned  in  1  1=zero-extend, 0=sign-extend.
- in_byte_off  in  2  address bits [1:0] of the load.
- dm_rvalid  in  1  data-memory read data valid.
- dm_rdata  in  32  data-memory read word (little-endian lanes).
- rwd  out  5  regfile write address; 0 = no write.
- wb_data  out  32  regfile write data.
- wb_pend_dst  out  5  destination of the load held in WAIT_LOAD, else 0 (hazard unit).
- err_timeout  out  1  sticky load-timeout flag.
- retired_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (RST=1 at posedge):
  - Outputs: rwd=0, wb_data=0, err_timeout=0, retired_cnt=0, wb_pend_dst=0.
  - State goes to IDLE and the timeout counter clears.
  - A load in flight is discarded.
- rwd and wb_data are registered and change only on posedge CLK, so they are stable when the regfile writes at the following negedge.
- rwd is nonzero for exactly one cycle per retired instruction and 0 in all other cycles.
- wb_data holds its last value when no retirement occurs.
- States: IDLE, WAIT_LOAD.
- IDLE (in_ready=1):
  - in_valid && !in_is_load: at the next posedge, rwd<=in_dst, wb_data<=in_alu, retired_cnt++. Stay IDLE; back-to-back ALU instructions retire one per cycle.
  - in_valid && in_is_load: capture dst, size, unsigned and byte_off, clear the timeout counter, go to WAIT_LOAD. rwd<=0.
  - In IDLE, dm_rvalid is ignored.
- WAIT_LOAD (in_ready=0, wb_pend_dst=captured dst):
  - dm_rvalid=1: rwd<=dst, wb_data<=extract(dm_rdata), retired_cnt++, go to IDLE. in_ready is 1 in the following cycle.
  - dm_rvalid=0: the counter increments.
  - Counter reaches LOAD_TIMEOUT-1 with dm_rvalid=0: err_timeout<=1 (sticky until RST), rwd<=0, no count increment, go to IDLE.
  - dm_rvalid on the timeout cycle takes priority; the load retires normally.
- Extract rules:
  - Byte: lane = byte_off, bits [8*off+7 : 8*off].
  - Half: lane = byte_off[1] (upper half if 1); byte_off[0] is ignored for misaligned halves.
  - Word/size 3: dm_rdata unmodified.
  - Sign extension uses the lane MSB unless in_ld_unsigned=1.
- dst=0 instruction: retires normally (counted, wb_data updated), but rwd=0 so no register is written.
- retired_cnt wraps modulo 2^CNT_W.

Test Plan:
- Reset then three back-to-back ALU instrs (dst 3/4/5, alu 0x11/0x22/0x33) → rwd=3,4,5 on consecutive cycles with matching wb_data; retired_cnt=3; in_ready stays 1.
- Signed byte load, off=2, dm_rvalid 3 cycles later with dm_rdata=0x12_80_34_56, dst=7 → in_ready=0 for 4 cycles; wb_pend_dst=7; then rwd=7, wb_data=0xFFFFFF80.
- Unsigned half load off=2, rdata=0x8001_ABCD → wb_data=0x00008001. Signed half off=0 → 0xFFFFABCD. Word load → 0x8001ABCD.
- Load with dm_rvalid never asserted, LOAD_TIMEOUT=16 → rwd stays 0; err_timeout=1 after 16 WAIT cycles; returns to IDLE; next ALU instr retires normally; err stays 1.
- RST asserted mid-WAIT_LOAD, then dm_rvalid pulsed after release → no write (rwd=0); err_timeout=0; retired_cnt=0; in_ready=1.
- ALU instr with dst=0, alu=0xDEAD → rwd=0, wb_data=0xDEAD, retired_cnt increments.
